execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Stage directly downstream of the registered fetch/decode outputs.
- Holds the 32x32 general register file and the HI/LO pair.
- Reads operands, executes the MIPS integer ALU subset in one cycle, and runs MULT/MULTU as an iterative 32-cycle shift-add with upstream stall.
- Drives a registered result bundle to the memory/writeback stage and takes that stage's write-back port.

Parameters:
- MUL_CYCLES, 32, number of iteration cycles for MULT/MULTU. Fixed to 32; exposed for bench visibility only.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts an instruction this cycle.
- w_op_type_6  in  6  opcode field.
- w_func_6  in  6  R-type function field.
- w_rs_5  in  5  rs address.
- w_rt_5  in  5  rt address.
- w_rd_5  in  5  rd address.
- w_sh_5  in  5  shift amount.
- w_alu_imm_16  in  16  immediate field.
- wb_en  in  1  register-file write enable from writeback.
- wb_addr_5  in  5  write-back address.
- wb_data_32  in  32  write-back data.
- out_valid  out  1  result bundle valid.
- out_we  out  1  result targets a GPR.
- out_dest_5  out  5  destination register.
- out_result_32  out  32  result value.

Behaviour:
- Reset (reset=0 at a rising edge):
  - All outputs 0, including in_ready. in_ready rises on the first edge with reset=1.
  - All GPRs, HI and LO cleared; state returns to RUN.
  - Reset mid-multiply aborts the multiply; HI/LO end at 0.
- Accept: instruction is taken on an edge with in_valid=1 and in_ready=1.
  - out_* are registered at that same edge, so single-cycle latency.
  - out_valid=0 on any edge without an accept, except the multiply-completion edge.
- Register file:
  - Reads are combinational.
  - Write happens on the edge when wb_en=1 and wb_addr_5 != 0.
  - $0 always reads 0.
  - Bypass: if wb_en=1 and wb_addr_5 equals a nonzero read address in the same cycle, the read returns wb_data_32.
- R-type (op 0x00):
  - ADD 0x20 and ADDU 0x21: rs+rt.
  - SUB 0x22 and SUBU 0x23: rs-rt.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A (signed compare) and SLTU 0x2B (unsigned), result 0 or 1.
  - SLL 0x00 / SRL 0x02 / SRA 0x03: rt shifted by w_sh_5.
  - MFHI 0x10 and MFLO 0x12.
  - dest = rd; out_we = 1 if rd != 0.
- I-type:
  - ADDI 0x08 / ADDIU 0x09 / SLTI 0x0A / SLTIU 0x0B use the sign-extended immediate. SLTIU compares unsigned after sign extension.
  - ANDI 0x0C / ORI 0x0D / XORI 0x0E use the zero-extended immediate.
  - LUI 0x0F: imm<<16.
  - dest = rt; out_we = 1 if rt != 0.
- Arithmetic: 32-bit wrap-around. No overflow traps, so ADD behaves as ADDU.
- Unsupported opcode/func: out_valid=1, out_we=0, out_result_32=0, out_dest_5=0.
- State machine RUN / MUL:
  - RUN: in_ready=1. Accepting MULT 0x18 or MULTU 0x19 latches rs/rt and enters MUL. Operands for MULT are absolute values with a sign flag. No out_valid on the accept edge.
  - MUL: in_ready=0. A 6-bit counter runs 0..31 with one shift-add per cycle.
  - On the 32nd MUL edge: {HI,LO} is written (negated 64-bit product when the sign flag is set), then out_valid=1, out_we=0, out_dest_5=0, out_result_32=LO. State returns to RUN.
  - Timing: accept at edge N, in_ready low after N through edge N+32, in_ready high after N+32.
- MFHI/MFLO issued right after a multiply always see the updated HI/LO, because stall enforces this.
- wb writes continue during MUL.
- in_valid while in_ready=0 is ignored. Upstream holds the instruction.

Test Plan:
- Reset held 2 cycles then released -> all outputs 0 during reset; in_ready=1 one cycle after release; reading $5 gives 0.
- wb $1=0x7FFFFFFF, $2=1; ADD rd=3 -> next cycle out_valid=1, out_we=1, dest 3, result 0x80000000. SLT rd=4 with rs=3 (after wb of 0x80000000), rt=2 -> result 1.
- ADDI rt=5 rs=0 imm 0xFFFF -> 0xFFFFFFFF. ORI imm 0xFFFF -> 0x0000FFFF. LUI imm 0x1234 -> 0x12340000. ADDI with rt=0 -> out_we=0.
- MULT with rs=-3 and rt=7 -> in_ready low for exactly 32 cycles, completion pulse out_we=0, then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFEB. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE.
- Same-cycle wb_en to $6=0xA5A5A5A5 while issuing OR rd=7 with rs=6, rt=0 -> result 0xA5A5A5A5 via bypass. wb to $0 -> $0 still reads 0.
- Reset asserted at MUL counter 10 -> no completion pulse; HI=LO=0; in_ready=1 after release.

Source files
------------

// File: rtl/execute_stage_if.sv
// Bundles the decoded-instruction handshake, write-back port and result bundle
// between fetch/decode, the execute stage and memory/writeback.
// Ports: in_valid/in_ready plus w_* instruction fields, wb_* register write port,
//        out_* registered result bundle. master = environment side, slave = execute stage.
interface execute_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  w_op_type_6;
  logic [5:0]  w_func_6;
  logic [4:0]  w_rs_5;
  logic [4:0]  w_rt_5;
  logic [4:0]  w_rd_5;
  logic [4:0]  w_sh_5;
  logic [15:0] w_alu_imm_16;
  logic        wb_en;
  logic [4:0]  wb_addr_5;
  logic [31:0] wb_data_32;
  logic        out_valid;
  logic        out_we;
  logic [4:0]  out_dest_5;
  logic [31:0] out_result_32;

  modport master (
    output in_valid, w_op_type_6, w_func_6, w_rs_5, w_rt_5, w_rd_5, w_sh_5,
           w_alu_imm_16, wb_en, wb_addr_5, wb_data_32,
    input  in_ready, out_valid, out_we, out_dest_5, out_result_32
  );

  modport slave (
    input  in_valid, w_op_type_6, w_func_6, w_rs_5, w_rt_5, w_rd_5, w_sh_5,
           w_alu_imm_16, wb_en, wb_addr_5, wb_data_32,
    output in_ready, out_valid, out_we, out_dest_5, out_result_32
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS integer execute stage: GPR file, HI/LO, one-cycle ALU, 32-cycle MULT/MULTU.
// Latency: ALU result registered on the accept edge; multiply completes 32 edges after accept.
// Backpressure: in_ready drops for the whole multiply; upstream holds its instruction.
// Ports: clock, reset (sync, active-low), bus (execute_stage_if.slave).
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic         clock,
  input  logic         reset,
  execute_stage_if.slave bus
);

  typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] gpr [32];
  logic [31:0] hi, lo;

  logic [5:0]  mul_cnt;
  logic [63:0] mul_acc, mul_mcand;
  logic [31:0] mul_mplier;
  logic        mul_neg;

  logic        ready_q, valid_q, we_q;
  logic [4:0]  dest_q;
  logic [31:0] result_q;

  logic        accept;
  logic [31:0] rs_val, rt_val, simm, zimm;
  logic [31:0] alu_res;
  logic        alu_ok, alu_rtype, is_mul, mul_signed;
  logic [4:0]  alu_dest;
  logic        mul_done;
  logic [63:0] mul_sum, mul_final;
  logic [31:0] mul_a, mul_b;

  assign accept = bus.in_valid & ready_q;

  // Combinational read with same-cycle write-back bypass; $0 is hardwired to zero.
  always_comb begin
    rs_val = 32'd0;
    rt_val = 32'd0;
    if (bus.w_rs_5 != 5'd0)
      rs_val = (bus.wb_en && bus.wb_addr_5 == bus.w_rs_5) ? bus.wb_data_32 : gpr[bus.w_rs_5];
    if (bus.w_rt_5 != 5'd0)
      rt_val = (bus.wb_en && bus.wb_addr_5 == bus.w_rt_5) ? bus.wb_data_32 : gpr[bus.w_rt_5];
  end

  assign simm = {{16{bus.w_alu_imm_16[15]}}, bus.w_alu_imm_16};
  assign zimm = {16'd0, bus.w_alu_imm_16};

  always_comb begin
    alu_res    = 32'd0;
    alu_ok     = 1'b1;
    alu_rtype  = 1'b0;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    alu_dest   = 5'd0;
    case (bus.w_op_type_6)
      6'h00: begin
        alu_rtype = 1'b1;
        case (bus.w_func_6)
          6'h20, 6'h21: alu_res = rs_val + rt_val;
          6'h22, 6'h23: alu_res = rs_val - rt_val;
          6'h24: alu_res = rs_val & rt_val;
          6'h25: alu_res = rs_val | rt_val;
          6'h26: alu_res = rs_val ^ rt_val;
          6'h27: alu_res = ~(rs_val | rt_val);
          6'h2A: alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2B: alu_res = {31'd0, rs_val < rt_val};
          6'h00: alu_res = rt_val << bus.w_sh_5;
          6'h02: alu_res = rt_val >> bus.w_sh_5;
          6'h03: alu_res = $signed(rt_val) >>> bus.w_sh_5;
          6'h10: alu_res = hi;
          6'h12: alu_res = lo;
          6'h18: begin alu_ok = 1'b0; is_mul = 1'b1; mul_signed = 1'b1; end
          6'h19: begin alu_ok = 1'b0; is_mul = 1'b1; end
          default: alu_ok = 1'b0;
        endcase
      end
      6'h08, 6'h09: alu_res = rs_val + simm;
      6'h0A: alu_res = {31'd0, $signed(rs_val) < $signed(simm)};
      6'h0B: alu_res = {31'd0, rs_val < simm};
      6'h0C: alu_res = rs_val & zimm;
      6'h0D: alu_res = rs_val | zimm;
      6'h0E: alu_res = rs_val ^ zimm;
      6'h0F: alu_res = {bus.w_alu_imm_16, 16'd0};
      default: alu_ok = 1'b0;
    endcase
    if (alu_ok)
      alu_dest = alu_rtype ? bus.w_rd_5 : bus.w_rt_5;
    else
      alu_res = 32'd0;
  end

  // Signed multiply runs on magnitudes; the sign is reapplied to the 64-bit product.
  assign mul_a     = (mul_signed && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
  assign mul_b     = (mul_signed && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
  assign mul_done  = (state == MUL) && (mul_cnt == 6'(MUL_CYCLES - 1));
  assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : 64'd0);
  assign mul_final = mul_neg ? (64'd0 - mul_sum) : mul_sum;

  always_ff @(posedge clock) begin
    if (!reset) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (accept && is_mul) state_next = MUL;
      MUL:     if (mul_done) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      mul_cnt    <= 6'd0;
      mul_acc    <= 64'd0;
      mul_mcand  <= 64'd0;
      mul_mplier <= 32'd0;
      mul_neg    <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      dest_q     <= 5'd0;
      result_q   <= 32'd0;
    end else begin
      if (bus.wb_en && bus.wb_addr_5 != 5'd0)
        gpr[bus.wb_addr_5] <= bus.wb_data_32;

      valid_q  <= 1'b0;
      we_q     <= 1'b0;
      dest_q   <= 5'd0;
      result_q <= 32'd0;
      ready_q  <= (state_next == RUN);

      if (accept) begin
        if (is_mul) begin
          mul_cnt    <= 6'd0;
          mul_acc    <= 64'd0;
          mul_mcand  <= {32'd0, mul_a};
          mul_mplier <= mul_b;
          mul_neg    <= mul_signed & (rs_val[31] ^ rt_val[31]);
        end else begin
          valid_q  <= 1'b1;
          we_q     <= (alu_dest != 5'd0);
          dest_q   <= alu_dest;
          result_q <= alu_res;
        end
      end

      if (state == MUL) begin
        if (mul_done) begin
          hi       <= mul_final[63:32];
          lo       <= mul_final[31:0];
          valid_q  <= 1'b1;
          result_q <= mul_final[31:0];
        end else begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 6'd1;
        end
      end
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_we        = we_q;
  assign bus.out_dest_5    = dest_q;
  assign bus.out_result_32 = result_q;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  execute_stage_if ifc();

  execute_stage #(.MUL_CYCLES(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic we,
                           input logic [4:0] dest, input logic [31:0] res);
    check({name, ".valid"},  {31'd0, ifc.out_valid}, {31'd0, v});
    check({name, ".we"},     {31'd0, ifc.out_we}, {31'd0, we});
    check({name, ".dest"},   {27'd0, ifc.out_dest_5}, {27'd0, dest});
    check({name, ".result"}, ifc.out_result_32, res);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm);
    ifc.w_op_type_6  = op;
    ifc.w_func_6     = func;
    ifc.w_rs_5       = rs;
    ifc.w_rt_5       = rt;
    ifc.w_rd_5       = rd;
    ifc.w_sh_5       = sh;
    ifc.w_alu_imm_16 = imm;
  endtask

  // One accept: drive on the falling edge, sample 1ns after the rising edge.
  task automatic issue(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    @(negedge clock);
    set_instr(op, func, rs, rt, rd, 5'd0, 16'd0);
    ifc.in_valid = 1'b1;
    @(posedge clock);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    ifc.wb_en      = 1'b1;
    ifc.wb_addr_5  = addr;
    ifc.wb_data_32 = data;
    @(posedge clock);
    #1;
    ifc.wb_en = 1'b0;
  endtask

  // Issues a multiply, holds an unrelated instruction on in_valid while stalled,
  // and reports stall length, stray pulses and the completion bundle.
  task automatic run_mul(input string name, input logic [5:0] func, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] exp_lo);
    int cycles = 0;
    int pulses = 0;
    issue(6'h00, func, rs, rt, 5'd0);
    check({name, ".accept_valid"}, {31'd0, ifc.out_valid}, 32'd0);
    check({name, ".accept_ready"}, {31'd0, ifc.in_ready}, 32'd0);
    set_instr(6'h08, 6'h00, 5'd1, 5'd20, 5'd0, 5'd0, 16'h0001);
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      cycles++;
      if (ifc.in_ready) break;
      if (ifc.out_valid) pulses++;
    end
    ifc.in_valid = 1'b0;
    check({name, ".stall_cycles"}, cycles, 32'd32);
    check({name, ".stray_pulses"}, pulses, 32'd0);
    check_out({name, ".done"}, 1'b1, 1'b0, 5'd0, exp_lo);
    @(posedge clock);
    #1;
    check({name, ".held_instr_ignored"}, {31'd0, ifc.out_valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    ifc.in_valid = 1'b0;
    ifc.wb_en    = 1'b0;
    ifc.wb_addr_5  = 5'd0;
    ifc.wb_data_32 = 32'd0;
    set_instr(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);

    vecs[0]  = '{"rd_zero_reg5", 6'h00, 6'h25, 5'd5, 5'd0, 5'd8,  5'd0, 16'h0000, 1'b1, 5'd8,  32'h0000_0000};
    vecs[1]  = '{"add_wrap",     6'h00, 6'h20, 5'd1, 5'd2, 5'd3,  5'd0, 16'h0000, 1'b1, 5'd3,  32'h8000_0000};
    vecs[2]  = '{"addu",         6'h00, 6'h21, 5'd1, 5'd2, 5'd3,  5'd0, 16'h0000, 1'b1, 5'd3,  32'h8000_0000};
    vecs[3]  = '{"sub",          6'h00, 6'h22, 5'd2, 5'd1, 5'd9,  5'd0, 16'h0000, 1'b1, 5'd9,  32'h8000_0002};
    vecs[4]  = '{"slt",          6'h00, 6'h2A, 5'd3, 5'd2, 5'd4,  5'd0, 16'h0000, 1'b1, 5'd4,  32'h0000_0001};
    vecs[5]  = '{"sltu",         6'h00, 6'h2B, 5'd3, 5'd2, 5'd4,  5'd0, 16'h0000, 1'b1, 5'd4,  32'h0000_0000};
    vecs[6]  = '{"and",          6'h00, 6'h24, 5'd1, 5'd3, 5'd10, 5'd0, 16'h0000, 1'b1, 5'd10, 32'h0000_0000};
    vecs[7]  = '{"nor",          6'h00, 6'h27, 5'd0, 5'd2, 5'd10, 5'd0, 16'h0000, 1'b1, 5'd10, 32'hFFFF_FFFE};
    vecs[8]  = '{"xor",          6'h00, 6'h26, 5'd1, 5'd3, 5'd10, 5'd0, 16'h0000, 1'b1, 5'd10, 32'hFFFF_FFFF};
    vecs[9]  = '{"sll",          6'h00, 6'h00, 5'd0, 5'd1, 5'd11, 5'd4, 16'h0000, 1'b1, 5'd11, 32'hFFFF_FFF0};
    vecs[10] = '{"srl",          6'h00, 6'h02, 5'd0, 5'd3, 5'd11, 5'd4, 16'h0000, 1'b1, 5'd11, 32'h0800_0000};
    vecs[11] = '{"sra",          6'h00, 6'h03, 5'd0, 5'd3, 5'd11, 5'd4, 16'h0000, 1'b1, 5'd11, 32'hF800_0000};
    vecs[12] = '{"addi_sext",    6'h08, 6'h00, 5'd0, 5'd5, 5'd0,  5'd0, 16'hFFFF, 1'b1, 5'd5,  32'hFFFF_FFFF};
    vecs[13] = '{"ori_zext",     6'h0D, 6'h00, 5'd0, 5'd5, 5'd0,  5'd0, 16'hFFFF, 1'b1, 5'd5,  32'h0000_FFFF};
    vecs[14] = '{"lui",          6'h0F, 6'h00, 5'd0, 5'd5, 5'd0,  5'd0, 16'h1234, 1'b1, 5'd5,  32'h1234_0000};
    vecs[15] = '{"addi_rt0",     6'h08, 6'h00, 5'd1, 5'd0, 5'd0,  5'd0, 16'h0001, 1'b0, 5'd0,  32'h8000_0000};
    vecs[16] = '{"sltiu_sext",   6'h0B, 6'h00, 5'd2, 5'd6, 5'd0,  5'd0, 16'hFFFF, 1'b1, 5'd6,  32'h0000_0001};
    vecs[17] = '{"slti_neg",     6'h0A, 6'h00, 5'd2, 5'd6, 5'd0,  5'd0, 16'hFFFF, 1'b1, 5'd6,  32'h0000_0000};
    vecs[18] = '{"andi_zext",    6'h0C, 6'h00, 5'd1, 5'd6, 5'd0,  5'd0, 16'h8F0F, 1'b1, 5'd6,  32'h0000_8F0F};
    vecs[19] = '{"bad_opcode",   6'h3F, 6'h00, 5'd1, 5'd6, 5'd7,  5'd0, 16'h1234, 1'b0, 5'd0,  32'h0000_0000};

    // Reset held for two edges, outputs all zero, in_ready one edge after release.
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check_out($sformatf("reset%0d", i), 1'b0, 1'b0, 5'd0, 32'd0);
      check($sformatf("reset%0d.in_ready", i), {31'd0, ifc.in_ready}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("release.in_ready", {31'd0, ifc.in_ready}, 32'd1);

    wb(5'd1, 32'h7FFF_FFFF);
    wb(5'd2, 32'h0000_0001);
    wb(5'd3, 32'h8000_0000);

    foreach (vecs[i]) begin
      @(negedge clock);
      set_instr(vecs[i].op, vecs[i].func, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm);
      ifc.in_valid = 1'b1;
      @(posedge clock);
      #1;
      ifc.in_valid = 1'b0;
      check_out(vecs[i].name, 1'b1, vecs[i].we, vecs[i].dest, vecs[i].res);
    end
    issue(6'h00, 6'h01, 5'd1, 5'd2, 5'd7);
    check_out("bad_func", 1'b1, 1'b0, 5'd0, 32'd0);
    @(posedge clock);
    #1;
    check("idle.valid", {31'd0, ifc.out_valid}, 32'd0);

    // Same-cycle write-back bypass, then the written value from the file, then $0.
    @(negedge clock);
    ifc.wb_en      = 1'b1;
    ifc.wb_addr_5  = 5'd6;
    ifc.wb_data_32 = 32'hA5A5_A5A5;
    set_instr(6'h00, 6'h25, 5'd6, 5'd0, 5'd7, 5'd0, 16'd0);
    ifc.in_valid = 1'b1;
    @(posedge clock);
    #1;
    ifc.in_valid = 1'b0;
    ifc.wb_en    = 1'b0;
    check_out("bypass", 1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5);
    issue(6'h00, 6'h25, 5'd6, 5'd0, 5'd7);
    check("gpr6_stored", ifc.out_result_32, 32'hA5A5_A5A5);
    wb(5'd0, 32'hDEAD_BEEF);
    issue(6'h00, 6'h25, 5'd0, 5'd0, 5'd7);
    check("r0_stays_zero", ifc.out_result_32, 32'd0);

    // Signed multiply -3 * 7.
    wb(5'd12, 32'hFFFF_FFFD);
    wb(5'd13, 32'h0000_0007);
    run_mul("mult", 6'h18, 5'd12, 5'd13, 32'hFFFF_FFEB);
    issue(6'h00, 6'h10, 5'd0, 5'd0, 5'd14);
    check_out("mfhi_mult", 1'b1, 1'b1, 5'd14, 32'hFFFF_FFFF);
    issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd14);
    check_out("mflo_mult", 1'b1, 1'b1, 5'd14, 32'hFFFF_FFEB);

    // Unsigned multiply 0xFFFFFFFF * 2.
    wb(5'd15, 32'hFFFF_FFFF);
    wb(5'd16, 32'h0000_0002);
    run_mul("multu", 6'h19, 5'd15, 5'd16, 32'hFFFF_FFFE);
    issue(6'h00, 6'h10, 5'd0, 5'd0, 5'd14);
    check("mfhi_multu", ifc.out_result_32, 32'h0000_0001);
    issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd14);
    check("mflo_multu", ifc.out_result_32, 32'hFFFF_FFFE);

    // Reset while the multiply counter sits at 10.
    issue(6'h00, 6'h18, 5'd12, 5'd13, 5'd0);
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_out("mul_reset", 1'b0, 1'b0, 5'd0, 32'd0);
    check("mul_reset.in_ready", {31'd0, ifc.in_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mul_reset.release_ready", {31'd0, ifc.in_ready}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (ifc.out_valid) pulses++;
    end
    check("mul_reset.no_completion", pulses, 32'd0);
    issue(6'h00, 6'h10, 5'd0, 5'd0, 5'd14);
    check("mul_reset.hi", ifc.out_result_32, 32'd0);
    issue(6'h00, 6'h12, 5'd0, 5'd0, 5'd14);
    check("mul_reset.lo", ifc.out_result_32, 32'd0);
    issue(6'h00, 6'h25, 5'd12, 5'd0, 5'd14);
    check("mul_reset.gpr_cleared", ifc.out_result_32, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
